// File: rtl/wide_to_narrow_stream_fifo_if.sv
// Handshake bundle for the wide-write / narrow-read stream FIFO.
// master drives writes and consumes lanes; slave is the FIFO itself.
interface wide_to_narrow_stream_fifo_if #(
  parameter int unsigned C_WR_WIDTH = 32,
  parameter int unsigned C_RD_WIDTH = 16,
  parameter int unsigned C_WR_DEPTH = 512
);
  localparam int unsigned Ratio = C_WR_WIDTH / C_RD_WIDTH;
  localparam int unsigned CntW  = $clog2(C_WR_DEPTH * Ratio) + 1;

  logic                  flush;
  logic                  wren;
  logic [C_WR_WIDTH-1:0] din;
  logic                  full;
  logic                  rden;
  logic [C_RD_WIDTH-1:0] dout;
  logic                  valid;
  logic                  empty;
  logic [CntW-1:0]       count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wren, din, rden,
    input  full, dout, valid, empty, count, overflow, underflow
  );

  modport slave (
    input  flush, wren, din, rden,
    output full, dout, valid, empty, count, overflow, underflow
  );
endinterface

// File: rtl/wide_to_narrow_stream_fifo.sv
// Single-clock FIFO: wide words in, narrow lanes out (LS lane first), FWFT read side.
// Block RAM with registered read feeds a one-word prefetch stage and an output word register.
module wide_to_narrow_stream_fifo #(
  parameter int unsigned C_WR_WIDTH = 32,
  parameter int unsigned C_RD_WIDTH = 16,
  parameter int unsigned C_WR_DEPTH = 512
) (
  input logic                          clk,
  input logic                          rst,
  wide_to_narrow_stream_fifo_if.slave  bus
);
  localparam int unsigned Ratio = C_WR_WIDTH / C_RD_WIDTH;
  localparam int unsigned PtrW  = $clog2(C_WR_DEPTH);
  localparam int unsigned CntW  = $clog2(C_WR_DEPTH * Ratio) + 1;
  localparam int unsigned LaneW = (Ratio > 1) ? $clog2(Ratio) : 1;

  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);
  localparam logic [PtrW:0]    DepthW   = (PtrW + 1)'(C_WR_DEPTH);
  localparam logic [CntW-1:0]  RatioC   = CntW'(Ratio);
  localparam logic [CntW-1:0]  RatioM1C = CntW'(Ratio - 1);

  logic [C_WR_WIDTH-1:0] mem [C_WR_DEPTH];
  logic [C_WR_WIDTH-1:0] ram_q;

  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]         fetch_cnt_q, fetch_cnt_d;
  logic [PtrW:0]         word_cnt_q, word_cnt_d;
  logic [CntW-1:0]       lane_cnt_q, lane_cnt_d;
  logic                  ram_vld_q, ram_vld_d;
  logic                  valid_q, valid_d;
  logic [LaneW-1:0]      lane_q, lane_d;
  logic [C_WR_WIDTH-1:0] word_q, word_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic wr_acc, rd_acc, release_word, out_load, fetch;

  assign wr_acc       = bus.wren && !full_q && !bus.flush;
  assign rd_acc       = bus.rden && valid_q && !bus.flush;
  assign release_word = rd_acc && (lane_q == LastLane);
  // The prefetched word moves to the output exactly when the previous word's last lane goes.
  assign out_load     = ram_vld_q && (!valid_q || release_word) && !bus.flush;
  assign fetch        = (fetch_cnt_q != '0) && (!ram_vld_q || out_load) && !bus.flush;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.din;
    if (fetch)  ram_q <= mem[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fetch_cnt_d = fetch_cnt_q;
    word_cnt_d  = word_cnt_q;
    lane_cnt_d  = lane_cnt_q;
    ram_vld_d   = ram_vld_q;
    valid_d     = valid_q;
    lane_d      = lane_q;
    word_d      = word_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;

    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      fetch_cnt_d = '0;
      word_cnt_d  = '0;
      lane_cnt_d  = '0;
      ram_vld_d   = 1'b0;
      valid_d     = 1'b0;
      lane_d      = '0;
      word_d      = '0;
    end else begin
      if (bus.wren && full_q)   ovf_d = 1'b1;
      if (bus.rden && !valid_q) unf_d = 1'b1;

      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (fetch)  rd_ptr_d = rd_ptr_q + 1'b1;

      case ({wr_acc, fetch})
        2'b10:   fetch_cnt_d = fetch_cnt_q + 1'b1;
        2'b01:   fetch_cnt_d = fetch_cnt_q - 1'b1;
        default: fetch_cnt_d = fetch_cnt_q;
      endcase

      case ({wr_acc, release_word})
        2'b10:   word_cnt_d = word_cnt_q + 1'b1;
        2'b01:   word_cnt_d = word_cnt_q - 1'b1;
        default: word_cnt_d = word_cnt_q;
      endcase

      case ({wr_acc, rd_acc})
        2'b10:   lane_cnt_d = lane_cnt_q + RatioC;
        2'b01:   lane_cnt_d = lane_cnt_q - 1'b1;
        2'b11:   lane_cnt_d = lane_cnt_q + RatioM1C;
        default: lane_cnt_d = lane_cnt_q;
      endcase

      if (fetch)         ram_vld_d = 1'b1;
      else if (out_load) ram_vld_d = 1'b0;

      if (rd_acc) lane_d = release_word ? '0 : lane_q + 1'b1;

      if (out_load) begin
        valid_d = 1'b1;
        word_d  = ram_q;
      end else if (release_word) begin
        valid_d = 1'b0;
      end
    end

    full_d = (word_cnt_d == DepthW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fetch_cnt_q <= '0;
      word_cnt_q  <= '0;
      lane_cnt_q  <= '0;
      ram_vld_q   <= 1'b0;
      valid_q     <= 1'b0;
      lane_q      <= '0;
      word_q      <= '0;
      full_q      <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fetch_cnt_q <= fetch_cnt_d;
      word_cnt_q  <= word_cnt_d;
      lane_cnt_q  <= lane_cnt_d;
      ram_vld_q   <= ram_vld_d;
      valid_q     <= valid_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      full_q      <= full_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  logic [Ratio-1:0][C_RD_WIDTH-1:0] lanes;
  assign lanes = word_q;

  if (Ratio == 1) begin : g_single_lane
    assign bus.dout = lanes[0];
  end else begin : g_multi_lane
    assign bus.dout = lanes[lane_q];
  end

  assign bus.valid     = valid_q;
  assign bus.empty     = !valid_q;
  assign bus.full      = full_q;
  assign bus.count     = lane_cnt_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: tb/tb_wide_to_narrow_stream_fifo.sv
// Scoreboard bench: writes push expected lanes, a negedge monitor pops on every consumed lane.
module tb_wide_to_narrow_stream_fifo;
  localparam int unsigned WrW   = 32;
  localparam int unsigned RdW   = 16;
  localparam int unsigned Depth = 512;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   chk_cnt;
  logic [RdW-1:0] exp_q[$];

  wide_to_narrow_stream_fifo_if #(
    .C_WR_WIDTH(WrW), .C_RD_WIDTH(RdW), .C_WR_DEPTH(Depth)
  ) bus ();

  wide_to_narrow_stream_fifo #(
    .C_WR_WIDTH(WrW), .C_RD_WIDTH(RdW), .C_WR_DEPTH(Depth)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [WrW-1:0] d);
    exp_q.push_back(d[15:0]);
    exp_q.push_back(d[31:16]);
  endtask

  // Accepted write only; dropped writes are driven inline without pushing.
  task automatic write_word(input logic [WrW-1:0] d);
    bus.wren = 1'b1;
    bus.din  = d;
    push_word(d);
    tick();
    bus.wren = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    int n = 0;
    while (!bus.valid && n < budget) begin
      tick();
      n++;
    end
    check("wait_valid", {31'd0, bus.valid}, 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Monitor: every lane consumed must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && !bus.flush && bus.valid && bus.rden) begin
      if (exp_q.size() == 0) begin
        check("lane_unexpected", {16'd0, bus.dout}, 32'hFFFF_FFFF);
      end else begin
        logic [RdW-1:0] e;
        e = exp_q.pop_front();
        check("lane_data", {16'd0, bus.dout}, {16'd0, e});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic started;
    int   n;
    pass_cnt  = 0;
    chk_cnt   = 0;
    rst       = 1'b1;
    bus.flush = 1'b0;
    bus.wren  = 1'b0;
    bus.rden  = 1'b0;
    bus.din   = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_dout", {16'd0, bus.dout}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_empty", {31'd0, bus.empty}, 32'd1);
    check("rst_full", {31'd0, bus.full}, 32'd0);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_unf", {31'd0, bus.underflow}, 32'd0);

    // Underflow on empty
    bus.rden = 1'b1;
    tick();
    bus.rden = 1'b0;
    check("unf_flag", {31'd0, bus.underflow}, 32'd1);
    check("unf_count", 32'(bus.count), 32'd0);
    check("unf_dout", {16'd0, bus.dout}, 32'd0);
    pulse_rst();
    check("unf_cleared", {31'd0, bus.underflow}, 32'd0);

    // Single word: valid after E2
    write_word(32'hBBBB_AAAA);
    check("sw_e0_count", 32'(bus.count), 32'd2);
    check("sw_e0_valid", {31'd0, bus.valid}, 32'd0);
    check("sw_e0_empty", {31'd0, bus.empty}, 32'd1);
    tick();
    check("sw_e1_valid", {31'd0, bus.valid}, 32'd0);
    tick();
    check("sw_e2_valid", {31'd0, bus.valid}, 32'd1);
    check("sw_e2_dout", {16'd0, bus.dout}, 32'h0000_AAAA);
    check("sw_e2_empty", {31'd0, bus.empty}, 32'd0);
    check("sw_e2_count", 32'(bus.count), 32'd2);
    bus.rden = 1'b1;
    tick();
    check("sw_r1_dout", {16'd0, bus.dout}, 32'h0000_BBBB);
    check("sw_r1_count", 32'(bus.count), 32'd1);
    tick();
    bus.rden = 1'b0;
    check("sw_r2_valid", {31'd0, bus.valid}, 32'd0);
    check("sw_r2_empty", {31'd0, bus.empty}, 32'd1);
    check("sw_r2_count", 32'(bus.count), 32'd0);

    // Fill, overflow, drain without bubbles
    for (int i = 0; i < Depth; i++) write_word(32'h0001_0000 + 32'(i));
    check("fill_full", {31'd0, bus.full}, 32'd1);
    check("fill_count", 32'(bus.count), 32'd1024);
    bus.wren = 1'b1;
    bus.din  = 32'hDEAD_BEEF;
    tick();
    bus.wren = 1'b0;
    check("fill_ovf", {31'd0, bus.overflow}, 32'd1);
    check("fill_ovf_count", 32'(bus.count), 32'd1024);
    bus.rden = 1'b1;
    for (int i = 0; i < 2 * Depth; i++) begin
      check("drain_valid", {31'd0, bus.valid}, 32'd1);
      tick();
    end
    bus.rden = 1'b0;
    check("drain_empty", {31'd0, bus.empty}, 32'd1);
    check("drain_count", 32'(bus.count), 32'd0);
    check("drain_full", {31'd0, bus.full}, 32'd0);

    // Streaming with pointer wrap: one write every other cycle, rden held
    started  = 1'b0;
    bus.rden = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (c % 2 == 0) begin
        logic [15:0] k;
        k        = 16'(c / 2);
        bus.wren = 1'b1;
        bus.din  = {16'hA5C3 ^ k, k};
        push_word(bus.din);
      end else begin
        bus.wren = 1'b0;
      end
      tick();
      if (started) check("stream_gap", {31'd0, bus.valid}, 32'd1);
      check("stream_full", {31'd0, bus.full}, 32'd0);
      if (bus.valid) started = 1'b1;
    end
    bus.wren = 1'b0;
    n = 0;
    while (bus.valid && n < 16) begin
      tick();
      n++;
    end
    bus.rden = 1'b0;
    check("stream_empty", {31'd0, bus.empty}, 32'd1);
    check("stream_leftover", 32'(exp_q.size()), 32'd0);

    // Full boundary: write dropped in the slot-freeing cycle, accepted next cycle
    pulse_rst();
    for (int i = 0; i < Depth; i++) write_word(32'h5555_0000 + 32'(i));
    check("fb_full", {31'd0, bus.full}, 32'd1);
    bus.rden = 1'b1;
    tick();
    bus.wren = 1'b1;
    bus.din  = 32'hDEAD_BEEF;
    tick();
    bus.wren = 1'b0;
    bus.rden = 1'b0;
    check("fb_ovf", {31'd0, bus.overflow}, 32'd1);
    check("fb_full_drop", {31'd0, bus.full}, 32'd0);
    check("fb_count_drop", 32'(bus.count), 32'd1022);
    write_word(32'h1234_5678);
    check("fb_full_again", {31'd0, bus.full}, 32'd1);
    check("fb_count_again", 32'(bus.count), 32'd1024);
    check("fb_dout", {16'd0, bus.dout}, 32'h0000_0001);

    // Flush clears contents but not the sticky overflow
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) write_word(32'h7000_0000 + 32'(i) * 32'h0001_0001);
    wait_valid(8);
    bus.rden = 1'b1;
    tick();
    bus.rden = 1'b0;
    check("fl_lane1", {16'd0, bus.dout}, 32'h0000_7000);
    check("fl_pre_count", 32'(bus.count), 32'd19);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    exp_q.delete();
    check("fl_valid", {31'd0, bus.valid}, 32'd0);
    check("fl_count", 32'(bus.count), 32'd0);
    check("fl_full", {31'd0, bus.full}, 32'd0);
    check("fl_empty", {31'd0, bus.empty}, 32'd1);
    check("fl_dout", {16'd0, bus.dout}, 32'd0);
    check("fl_ovf_kept", {31'd0, bus.overflow}, 32'd1);

    // Asynchronous reset mid-stream clears outputs between edges
    for (int i = 0; i < 10; i++) write_word(32'h9000_0000 + 32'(i) * 32'h0001_0001);
    wait_valid(8);
    bus.rden = 1'b1;
    tick();
    bus.rden = 1'b0;
    check("ar_lane1", {16'd0, bus.dout}, 32'h0000_9000);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", {31'd0, bus.valid}, 32'd0);
    check("ar_count", 32'(bus.count), 32'd0);
    check("ar_dout", {16'd0, bus.dout}, 32'd0);
    check("ar_full", {31'd0, bus.full}, 32'd0);
    check("ar_ovf", {31'd0, bus.overflow}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/wide_to_narrow_stream_fifo.md
# wide_to_narrow_stream_fifo

Single-clock FIFO that accepts wide words and emits them as a stream of narrow words, least-significant lane first. It is the read-side companion to the team's narrow-write/wide-read RAM: producers push full-width words, and consumers pull narrow lanes with a first-word-fall-through valid/consume handshake. It sits between wide datapath stages, such as accumulator or row writeback, and narrow serial consumers, such as DMA packers or output lanes.

## Interface
- C_WR_WIDTH, 32, input word width in bits; must be an integer multiple of C_RD_WIDTH.
- C_RD_WIDTH, 16, output lane width in bits; R = C_WR_WIDTH / C_RD_WIDTH is a power of two, 1 to 16.
- C_WR_DEPTH, 512, capacity in wide words; power of two, minimum 4.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all contents; takes priority over wren and rden.
- wren  input  1  write strobe; ignored when full=1.
- din  input  C_WR_WIDTH  write data.
- full  output  1  no free wide-word slot.
- rden  input  1  consume the current narrow lane; ignored when valid=0.
- dout  output  C_RD_WIDTH  current narrow lane; meaningful only while valid=1.
- valid  output  1  dout holds an unconsumed lane.
- empty  output  1  no unconsumed lanes anywhere in the block (equals !valid in steady state).
- count  output  clog2(C_WR_DEPTH*R)+1  unconsumed narrow lanes, including the one on dout.
- overflow  output  1  sticky flag; set by wren while full=1.
- underflow  output  1  sticky flag; set by rden while valid=0.

## Operation
- Reset, whether asynchronous or by flush: dout=0, valid=0, empty=1, full=0, count=0. Pointers and lane index return to 0. overflow and underflow clear only on rst, not on flush.
- Write: wren=1 with full=0 stores din at the write pointer, which wraps modulo C_WR_DEPTH.
- Lane order: the lane index starts at 0 and presents din[(k+1)*C_RD_WIDTH-1 : k*C_RD_WIDTH] for k = 0 to R-1.
- Consume: rden=1 with valid=1 advances the lane index. On lane R-1 the wide word is released, which frees its slot and advances the read pointer, and lane 0 of the next word follows.
- Slot occupancy: a partially consumed wide word occupies its slot until its last lane is consumed.
- full is registered. It is 1 when C_WR_DEPTH wide words are held, counting the partially consumed word. A write in the same cycle as a slot-freeing read while full=1 is dropped and sets overflow.
- Write on empty: the word falls through to dout automatically; no rden is required.
- Simultaneous wren and rden on a non-full, non-empty FIFO: both take effect. count changes by +R-1 in that cycle.
- count arithmetic: count += R per accepted write, and count -= 1 per accepted read. count never exceeds C_WR_DEPTH*R.
- Dropped operations: dropped writes and ignored reads change no state except the sticky flags.
- flush and rst mid-stream: any lane on dout is discarded. valid is 0 on the cycle after the clear.

## Timing
- Write-to-valid latency: wren sampled at edge E0 into an empty FIFO gives valid=1 and dout = lane 0 after edge E2.
- Throughput: one narrow lane per cycle sustained while data is available, with no bubble at wide-word boundaries. The next word is prefetched while the current word's lanes drain.
- rden effect: rden sampled at edge E with valid=1 updates dout, valid and count after E.
- full: asserts after the edge that accepts the C_WR_DEPTH-th word. It deasserts the edge after the last lane of a word is consumed.
- count and empty: update on the same edge as the accepted operation. Exception: after a write into an empty FIFO, empty stays 1 until valid rises at E2.
- Flags: overflow and underflow assert after the offending edge and hold until rst.
- Storage: the RAM is inferred as block RAM with one registered read port. There is no combinational path from din to dout.

## Test plan
Defaults C_WR_WIDTH=32, C_RD_WIDTH=16, C_WR_DEPTH=512, so R=2.

- Single word: write 0xBBBBAAAA into an empty FIFO at E0. Then valid=1 and dout=0xAAAA after E2, and count=2. Assert rden: dout=0xBBBB, count=1. Assert rden again: valid=0, empty=1, count=0.
- Fill and overflow: write 512 words 0x0001_0000+i. Then full=1 and count=1024. A 513th write is dropped and sets overflow=1. Drain 1024 lanes with rden held high; the lanes come out 0x0000, 0x0001, 0x0001, 0x0001, ... in order with no bubble. Then empty=1.
- Streaming with wrap: run wren 1 cycle in 2 together with continuous rden for 2000 cycles. No gaps in valid after the first word. Output matches the lane-split input sequence across pointer wrap. full never asserts.
- Full boundary: with full=1, assert rden on lane 1 and wren in the same cycle. The write is dropped and overflow=1. On the next cycle full=0 and a write is accepted.
- Underflow: assert rden at reset with valid=0. Then underflow=1, count stays 0, and dout=0.
- Mid-operation clear: with 10 words stored and dout=lane 1, assert flush. The next cycle shows valid=0, count=0, full=0, and overflow unchanged. Repeat the scenario with rst asserted asynchronously between edges: outputs clear immediately.
